// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register/data widths, the zero register and the
// destination tag carried alongside each in-flight instruction.
package cpu_pkg;

  localparam int NREG_W = 5;
  localparam int DATA_W = 32;

  localparam logic [NREG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              reg_en;
    logic              mem_read;
    logic [NREG_W-1:0] waddr;
  } tag_t;

  // Decode bubbles keep mem_read set, so liveness depends only on reg_en and waddr.
  function automatic logic tag_live(input tag_t t);
    return t.reg_en && (t.waddr != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side operand request / forwarding bundle between the pipeline
// (master) and the hazard unit (slave).
interface hazard_unit_if
  import cpu_pkg::*;
();

  logic [NREG_W-1:0] de_rs_addr;
  logic [NREG_W-1:0] de_rt_addr;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;
  logic              ex_reg_en;
  logic              ex_mem_read;
  logic [NREG_W-1:0] ex_reg_waddr;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] de_rs_data;
  logic [DATA_W-1:0] de_rt_data;
  logic              stall;
  logic [31:0]       stall_cnt;

  modport master (
    output de_rs_addr, de_rt_addr, rf_rs_data, rf_rt_data,
    output ex_reg_en, ex_mem_read, ex_reg_waddr,
    output ex_result, mem_result, wb_result,
    input  de_rs_data, de_rt_data, stall, stall_cnt
  );

  modport slave (
    input  de_rs_addr, de_rt_addr, rf_rs_data, rf_rt_data,
    input  ex_reg_en, ex_mem_read, ex_reg_waddr,
    input  ex_result, mem_result, wb_result,
    output de_rs_data, de_rt_data, stall, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand producer match, EX > MEM > WB > regfile priority select and
// hazard flag. HAZARD_FORWARD_EN selects bypassing; otherwise interlock only.
module hazard_fwd_sel
  import cpu_pkg::*;
(
  input  logic [NREG_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  tag_t              ex_tag,
  input  tag_t              mem_tag,
  input  tag_t              wb_tag,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    ex_hit  = (addr != REG_ZERO) && tag_live(ex_tag)  && (ex_tag.waddr  == addr);
    mem_hit = (addr != REG_ZERO) && tag_live(mem_tag) && (mem_tag.waddr == addr) && !ex_hit;
    wb_hit  = (addr != REG_ZERO) && tag_live(wb_tag)  && (wb_tag.waddr  == addr) && !ex_hit
              && !mem_hit;
  end

`ifdef HAZARD_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = wb_tag.mem_read;

  // A load's value is not on ex_result/mem_result, so EX/MEM load hits stall instead.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (ex_hit) begin
      if (ex_tag.mem_read) hazard = 1'b1;
      else                 data   = ex_result;
    end else if (mem_hit) begin
      if (mem_tag.mem_read) hazard = 1'b1;
      else                  data   = mem_result;
    end else if (wb_hit) begin
      data = wb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_result, wb_result,
                        ex_tag.mem_read, mem_tag.mem_read, wb_tag.mem_read};

  always_comb begin
    data   = rf_data;
    hazard = ex_hit || mem_hit || wb_hit;
  end
`endif

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage pipeline: shadow MEM/WB tag
// pipeline, per-operand selectors, stall OR and saturating stall counter.
// Optional bypassing is enabled by defining HAZARD_FORWARD_EN.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  hazard_unit_if.slave  hif
);

  tag_t        ex_tag;
  tag_t        mem_tag_d, mem_tag_q;
  tag_t        wb_tag_d,  wb_tag_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic        rs_hazard, rt_hazard;
  logic        stall;

  always_comb begin
    ex_tag.reg_en   = hif.ex_reg_en;
    ex_tag.mem_read = hif.ex_mem_read;
    ex_tag.waddr    = hif.ex_reg_waddr;
  end

  hazard_fwd_sel u_rs_sel (
    .addr       (hif.de_rs_addr),
    .rf_data    (hif.rf_rs_data),
    .ex_tag     (ex_tag),
    .mem_tag    (mem_tag_q),
    .wb_tag     (wb_tag_q),
    .ex_result  (hif.ex_result),
    .mem_result (hif.mem_result),
    .wb_result  (hif.wb_result),
    .data       (hif.de_rs_data),
    .hazard     (rs_hazard)
  );

  hazard_fwd_sel u_rt_sel (
    .addr       (hif.de_rt_addr),
    .rf_data    (hif.rf_rt_data),
    .ex_tag     (ex_tag),
    .mem_tag    (mem_tag_q),
    .wb_tag     (wb_tag_q),
    .ex_result  (hif.ex_result),
    .mem_result (hif.mem_result),
    .wb_result  (hif.wb_result),
    .data       (hif.de_rt_data),
    .hazard     (rt_hazard)
  );

  // Tags advance unconditionally: on a stall decode feeds a bubble into EX.
  always_comb begin
    mem_tag_d   = ex_tag;
    wb_tag_d    = mem_tag_q;
    stall       = rs_hazard || rt_hazard;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_tag_q   <= '0;
      wb_tag_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_tag_q   <= mem_tag_d;
      wb_tag_q    <= wb_tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hif.stall     = stall;
  assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus randomized traffic checked
// against a producer-history reference model (honours HAZARD_FORWARD_EN).
module tb_hazard_unit;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  hazard_unit_if hif ();

  hazard_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .hif    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       ld;
    bit [4:0] wa;
  } mtag_t;

  // hist[0] is the instruction now in MEM, hist[1] the one in WB.
  mtag_t       hist[$];
  logic [31:0] m_cnt;

  function automatic mtag_t cur_ex();
    mtag_t t;
    t.en = hif.ex_reg_en;
    t.ld = hif.ex_mem_read;
    t.wa = hif.ex_reg_waddr;
    return t;
  endfunction

  function automatic void ref_op(input logic [4:0] addr, input logic [31:0] rf,
                                 output logic [31:0] d, output bit haz);
    mtag_t       st [3];
    logic [31:0] val[3];
    mtag_t       none;
    bit          found;
    none  = '{en: 1'b0, ld: 1'b0, wa: 5'd0};
    st[0] = cur_ex();
    st[1] = (hist.size() > 0) ? hist[0] : none;
    st[2] = (hist.size() > 1) ? hist[1] : none;
    val[0] = hif.ex_result;
    val[1] = hif.mem_result;
    val[2] = hif.wb_result;
    d = rf;
    haz = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && addr != 5'd0 && st[k].en && st[k].wa == addr) begin
        found = 1'b1;
`ifdef HAZARD_FORWARD_EN
        if (st[k].ld && k < 2) haz = 1'b1;
        else                   d   = val[k];
`else
        haz = 1'b1;
`endif
      end
    end
  endfunction

  task automatic drive(input bit en, input bit ld, input logic [4:0] wa,
                       input logic [4:0] rs, input logic [4:0] rt);
    hif.ex_reg_en    = en;
    hif.ex_mem_read  = ld;
    hif.ex_reg_waddr = wa;
    hif.de_rs_addr   = rs;
    hif.de_rt_addr   = rt;
  endtask

  task automatic set_data(input logic [31:0] rfs, input logic [31:0] rft, input logic [31:0] exr,
                          input logic [31:0] memr, input logic [31:0] wbr);
    hif.rf_rs_data = rfs;
    hif.rf_rt_data = rft;
    hif.ex_result  = exr;
    hif.mem_result = memr;
    hif.wb_result  = wbr;
  endtask

  // Clock one edge and advance the model; returns 1 ns after the edge.
  task automatic advance();
    logic [31:0] d;
    bit hs, ht;
    mtag_t t;
    ref_op(hif.de_rs_addr, hif.rf_rs_data, d, hs);
    ref_op(hif.de_rt_addr, hif.rf_rt_data, d, ht);
    t = cur_ex();
    @(posedge clk);
    if (resetn) begin
      if ((hs || ht) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      hist.push_front(t);
      if (hist.size() > 2) void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    hist.delete();
    m_cnt = '0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_data('0, '0, '0, '0, '0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    hist.delete();
    m_cnt = '0;
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
    set_data(32'h1111, 32'h2222, 32'h3, 32'h4, 32'h5);
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", hif.stall); end
    total++;
    if (hif.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", hif.stall_cnt); end
    total++;
    if (hif.de_rs_data !== 32'h1111) begin bad++; $display("FAIL reset_rs: got %h want 1111", hif.de_rs_data); end
    total++;
    if (hif.de_rt_data !== 32'h2222) begin bad++; $display("FAIL reset_rt: got %h want 2222", hif.de_rt_data); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

`ifdef HAZARD_FORWARD_EN
  task automatic test_fwd_alu();
    do_reset();
    drive(1'b1, 1'b0, 5'd3, 5'd3, 5'd0);
    set_data(32'h999, 32'h0, 32'h11, 32'h22, 32'h33);
    #1;
    total++;
    if (hif.de_rs_data !== 32'h11) begin bad++; $display("FAIL fwd_alu_rs: got %h want 11", hif.de_rs_data); end
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL fwd_alu_stall: got %b want 0", hif.stall); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd4);
    set_data(32'h0, 32'h1234, 32'hBEEF, 32'hDEAD, 32'hCAFE);
    #1;
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL load_ex_stall: got %b want 1", hif.stall); end
    advance();
    drive(1'b0, 1'b1, 5'd4, 5'd0, 5'd4);
    #1;
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL load_mem_stall: got %b want 1", hif.stall); end
    advance();
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL load_wb_stall: got %b want 0", hif.stall); end
    total++;
    if (hif.de_rt_data !== 32'hCAFE) begin bad++; $display("FAIL load_wb_rt: got %h want cafe", hif.de_rt_data); end
    total++;
    if (hif.stall_cnt !== 32'd2) begin bad++; $display("FAIL load_cnt: got %0d want 2", hif.stall_cnt); end
  endtask

  task automatic test_dual_match();
    do_reset();
    drive(1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
    set_data(32'h70, 32'h71, 32'hB, 32'h0, 32'h0);
    advance();
    drive(1'b1, 1'b0, 5'd5, 5'd5, 5'd5);
    set_data(32'h70, 32'h71, 32'hA, 32'hB, 32'hC);
    #1;
    total++;
    if (hif.de_rs_data !== 32'hA) begin bad++; $display("FAIL dual_rs: got %h want a", hif.de_rs_data); end
    total++;
    if (hif.de_rt_data !== 32'hA) begin bad++; $display("FAIL dual_rt: got %h want a", hif.de_rt_data); end
    advance();
    drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd5);
    #1;
    total++;
    if (hif.de_rs_data !== 32'hB || hif.de_rt_data !== 32'hB) begin
      bad++; $display("FAIL dual_mem: got %h/%h want b/b", hif.de_rs_data, hif.de_rt_data);
    end
    advance();
    drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    total++;
    if (hif.de_rs_data !== 32'hC || hif.de_rt_data !== 32'hC) begin
      bad++; $display("FAIL dual_wb: got %h/%h want c/c", hif.de_rs_data, hif.de_rt_data);
    end
  endtask
`else
  task automatic test_interlock();
    do_reset();
    drive(1'b1, 1'b0, 5'd3, 5'd3, 5'd0);
    set_data(32'h4321, 32'h0, 32'h11, 32'h22, 32'h33);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (hif.stall !== 1'b1) begin bad++; $display("FAIL interlock_stall%0d: got %b want 1", c, hif.stall); end
      advance();
      drive(1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    end
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL interlock_release: got %b want 0", hif.stall); end
    total++;
    if (hif.de_rs_data !== 32'h4321) begin bad++; $display("FAIL interlock_rs: got %h want 4321", hif.de_rs_data); end
    total++;
    if (hif.stall_cnt !== 32'd3) begin bad++; $display("FAIL interlock_cnt: got %0d want 3", hif.stall_cnt); end
  endtask
`endif

  task automatic test_reg_zero();
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    set_data(32'h0, 32'h0, 32'h55, 32'h0, 32'h0);
    #1;
    total++;
    if (hif.de_rs_data !== 32'h0) begin bad++; $display("FAIL r0_rs: got %h want 0", hif.de_rs_data); end
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %b want 0", hif.stall); end
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL r0_load_stall: got %b want 0", hif.stall); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd4);
    set_data(32'h0, 32'h77, 32'h1, 32'h2, 32'h3);
    advance();
    drive(1'b0, 1'b1, 5'd4, 5'd0, 5'd4);
    #1;
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall: got %b want 1", hif.stall); end
    resetn = 1'b0;
    hist.delete();
    m_cnt = '0;
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall: got %b want 0", hif.stall); end
    total++;
    if (hif.stall_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", hif.stall_cnt); end
    drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd4);
    #1;
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL mid_rst_ex_load: got %b want 1", hif.stall); end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd4);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    total++;
    if (hif.stall !== 1'b0 || hif.de_rt_data !== 32'h77) begin
      bad++; $display("FAIL mid_release: got stall=%b rt=%h want 0/77", hif.stall, hif.de_rt_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] ers, ert;
    bit          hs, ht;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      set_data($urandom, $urandom, $urandom, $urandom, $urandom);
      #1;
      ref_op(hif.de_rs_addr, hif.rf_rs_data, ers, hs);
      ref_op(hif.de_rt_addr, hif.rf_rt_data, ert, ht);
      total++;
      if (hif.stall !== (hs || ht)) begin
        bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, hif.stall, hs || ht);
      end
      total++;
      if (hif.stall_cnt !== m_cnt) begin
        bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, hif.stall_cnt, m_cnt);
      end
      if (!(hs || ht)) begin
        total++;
        if (hif.de_rs_data !== ers || hif.de_rt_data !== ert) begin
          bad++;
          $display("FAIL rand_data[%0d]: got %h/%h want %h/%h", i, hif.de_rs_data, hif.de_rt_data, ers, ert);
        end
      end
      advance();
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b1;
    m_cnt  = '0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_data('0, '0, '0, '0, '0);
    test_reset();
`ifdef HAZARD_FORWARD_EN
    test_fwd_alu();
    test_load_use();
    test_dual_match();
`else
    test_interlock();
`endif
    test_reg_zero();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
